// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
// Contents: DEFAULT_CLKS_PER_BIT (50 MHz / 115200), DATA_W (byte width),
//           rx_state_t (receiver FSM states).
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DATA_W               = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DONE
    } rx_state_t;

endpackage

// File: rtl/uart_rx_frontend_if.sv
// rtl/uart_rx_frontend_if.sv - received-byte output bundle of the UART receiver
// Signals: Rx_DATA  last correctly received byte
//          Rx_VALID one-cycle strobe, Rx_DATA just updated
//          Rx_ERROR one-cycle strobe, framing error (stop bit low)
// Modports: master (receiver drives), slave (consumer reads).
interface uart_rx_frontend_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] Rx_DATA;
    logic              Rx_VALID;
    logic              Rx_ERROR;

    modport master (output Rx_DATA, output Rx_VALID, output Rx_ERROR);
    modport slave  (input  Rx_DATA, input  Rx_VALID, input  Rx_ERROR);

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for an asynchronous line input
// Ports: clk   system clock
//        reset asynchronous active-high reset, both flops reset to 1 (idle line)
//        d     asynchronous input
//        q     synchronized output
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// rtl/uart_rx_frontend.sv - 8N1 UART receiver with framing-error detection
// Parameter: CLKS_PER_BIT clk cycles per serial bit (4..65535)
// Ports: clk       system clock (rising edge)
//        reset     asynchronous active-high reset
//        Rx_Serial asynchronous UART line, idles high
//        rx        master side of uart_rx_frontend_if (Rx_DATA/Rx_VALID/Rx_ERROR)
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Rx_Serial,
    uart_rx_frontend_if.master  rx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic              rx_s;
    rx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              stop_ok_q, stop_ok_d;
    logic              armed_q, armed_d;
    logic              valid_q, valid_d;
    logic              error_q, error_d;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (Rx_Serial),
        .q     (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            stop_ok_q <= 1'b0;
            armed_q   <= 1'b1;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            stop_ok_q <= stop_ok_d;
            armed_q   <= armed_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        stop_ok_d = stop_ok_q;
        // After a framing error the line must be seen high again before a new
        // start bit is accepted, so a held-low break reports only once.
        armed_d   = armed_q | rx_s;
        valid_d   = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s && armed_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    stop_ok_d = rx_s;
                    if (rx_s) begin
                        data_d = shreg_q;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                // Strobes are registered here, so they appear the cycle after
                // DONE and are glitch-free at the output.
                valid_d = stop_ok_q;
                error_d = !stop_ok_q;
                if (!stop_ok_q) begin
                    armed_d = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx.Rx_DATA  = data_q;
    assign rx.Rx_VALID = valid_q;
    assign rx.Rx_ERROR = error_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb/tb_uart_rx_frontend.sv - self-checking bench for uart_rx_frontend
module tb_uart_rx_frontend;

    localparam int C   = 8;
    localparam int LAT = 2 + C / 2 + 9 * C + 1;

    logic clk = 1'b0;
    logic reset;
    logic Rx_Serial;

    uart_rx_frontend_if rx_if ();

    uart_rx_frontend #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .Rx_Serial (Rx_Serial),
        .rx        (rx_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         t;
        bit         err;
        logic [7:0] data;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];

    logic [7:0] last_good = 8'h00;

    int         overlap_n   = 0;
    int         double_n    = 0;
    int         unheld_n    = 0;
    logic       prev_valid  = 1'b0;
    logic       chg_pending = 1'b0;
    logic [7:0] prev_data   = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            prev_valid  = 1'b0;
            chg_pending = 1'b0;
            prev_data   = rx_if.Rx_DATA;
        end else begin
            if (rx_if.Rx_VALID && rx_if.Rx_ERROR) overlap_n++;
            if (prev_valid && rx_if.Rx_VALID) double_n++;
            if (chg_pending && !rx_if.Rx_VALID) unheld_n++;
            chg_pending = (rx_if.Rx_DATA !== prev_data) && !rx_if.Rx_VALID;
            if (rx_if.Rx_VALID) obs_q.push_back('{t: cyc, err: 1'b0, data: rx_if.Rx_DATA});
            if (rx_if.Rx_ERROR) obs_q.push_back('{t: cyc, err: 1'b1, data: rx_if.Rx_DATA});
            prev_valid = rx_if.Rx_VALID;
            prev_data  = rx_if.Rx_DATA;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is aligned at posedge+1; leaves the line at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input bit stop_hi);
        logic [9:0] bits;
        bits = {stop_hi, b, 1'b0};
        exp_q.push_back('{t: cyc + 1 + LAT, err: !stop_hi, data: stop_hi ? b : last_good});
        if (stop_hi) last_good = b;
        for (int k = 0; k < 10; k++) begin
            Rx_Serial = bits[k];
            repeat (C) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        Rx_Serial = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_events(input string tag);
        ev_t o;
        ev_t e;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_kind"}, o.err, e.err);
            check({tag, "_data"}, o.data, e.data);
            check({tag, "_time"}, o.t, e.t);
        end
        obs_q.delete();
        exp_q.delete();
        check({tag, "_held"}, rx_if.Rx_DATA, last_good);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        bit         rs;
        int         gap;

        reset     = 1'b1;
        Rx_Serial = 1'b1;
        #1;
        check("reset_data",  rx_if.Rx_DATA,  8'h00);
        check("reset_valid", rx_if.Rx_VALID, 1'b0);
        check("reset_error", rx_if.Rx_ERROR, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2 * C);

        send_frame(8'hA5, 1'b1);
        idle(3 * C);
        check_events("nominal");

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(3 * C);
        check_events("b2b");

        Rx_Serial = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(2 * C);
        check_events("glitch");
        send_frame(8'h5A, 1'b1);
        idle(3 * C);
        check_events("after_glitch");

        send_frame(8'h81, 1'b0);
        idle(3 * C);
        check_events("framing");

        Rx_Serial = 1'b0;
        repeat (C) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            rb = 8'h77;
            Rx_Serial = rb[k];
            repeat (C) @(posedge clk);
            #1;
        end
        repeat (C / 2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midreset_data",  rx_if.Rx_DATA,  8'h00);
        check("midreset_valid", rx_if.Rx_VALID, 1'b0);
        check("midreset_error", rx_if.Rx_ERROR, 1'b0);
        last_good = 8'h00;
        Rx_Serial = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2 * C);
        check_events("midreset_quiet");
        send_frame(8'hC3, 1'b1);
        idle(3 * C);
        check_events("after_reset");

        exp_q.push_back('{t: cyc + 1 + LAT, err: 1'b1, data: last_good});
        Rx_Serial = 1'b0;
        repeat (30 * C) @(posedge clk);
        #1;
        idle(2 * C);
        check_events("break");
        send_frame(8'h12, 1'b1);
        idle(3 * C);
        check_events("after_break");

        for (int n = 0; n < 24; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            send_frame(rb, rs);
            gap = rs ? (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2 * C)))
                     : int'($urandom_range(C, 2 * C));
            if (gap > 0) idle(gap);
        end
        idle(3 * C);
        check_events("random");

        check("strobe_overlap", overlap_n, 0);
        check("strobe_double",  double_n,  0);
        check("data_unheld",    unheld_n,  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
